mov_exec_fsm: RTL and testbench
===============================

Name: mov_exec_fsm

Overview:
- Parametrised execution FSM for register move instructions in the microcontroller datapath.
- Handles MOV (register to register) and MOVI (6-bit immediate to register) for a configurable general-register count.
- Bus settle time is configurable; the block pulses done once per executed instruction.
- Sits beside the other per-opcode FSMs. It drives one-hot register bus-out and bus-in enables, the immediate bus driver and the PC increment strobe.

Parameters:
- NUM_REGS, 6: number of general registers; width of rxOut/rxIn; legal indices 0..NUM_REGS-1 (max 64).
- MOV_OPC, 4'b0101: opcode for register-to-register move.
- MOVI_OPC, 4'b1101: opcode for immediate move.
- XFER_CYCLES, 1: cycles the XFER state holds bus enables (1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- instruction  input  16  current instruction; [15:12] opcode, [11:6] dst index, [5:0] src index or immediate; held stable by the controller.
- done  output  1  one-cycle pulse at instruction completion.
- pcInc  output  1  PC increment strobe.
- rxOut  output  NUM_REGS  one-hot register output enable; bit NUM_REGS-1 = reg0, bit 0 = reg NUM_REGS-1.
- rxIn  output  NUM_REGS  one-hot register load enable; same bit order as rxOut.
- immEn  output  1  drives immData onto the register bus.
- immData  output  6  immediate value (instruction[5:0]).
- err  output  1  illegal register index flag; present only with MOV_IDX_CHECK_EN.

Behaviour:
- Reset: when rst=1 at a clk edge, state goes to IDLE and the transfer counter is set to 0. All outputs are 0 while in IDLE.
- Outputs are a Moore decode of the present state plus the instruction fields. No output depends on rst combinationally.
- Active: opcode equals MOV_OPC or MOVI_OPC. If the opcode is not active at a clk edge, next state is IDLE from any state. This aborts mid-operation with no done pulse.
- States and transitions (when active):
  - IDLE -> SRC
  - SRC -> XFER
  - XFER stays for XFER_CYCLES cycles (counter counts 0..XFER_CYCLES-1), then -> DONE
  - DONE -> HOLD
  - HOLD -> HOLD until the opcode changes
- A new instruction with the same opcode does not restart execution. The controller inserts a non-move opcode for at least one cycle between moves.
- IDLE and HOLD outputs: done=0, pcInc=0, rxOut=0, rxIn=0, immEn=0, immData=0.
- SRC: pcInc=1 for exactly one cycle.
  - MOV: rxOut = onehot(src).
  - MOVI: immEn=1, immData=instruction[5:0], rxOut=0.
  - rxIn=0.
- XFER: pcInc=0. Source enables are held exactly as in SRC, and rxIn = onehot(dst).
- DONE: done=1, all other outputs 0.
- Latency with XFER_CYCLES=1: done is high in the 4th cycle after the opcode first becomes active in IDLE. In general, done appears at cycle 3+XFER_CYCLES.
- onehot(i) for i >= NUM_REGS is all zeros, so no register is driven or loaded. The sequence still completes and done still pulses.
- src == dst on MOV is legal: the same bit is set in rxOut and rxIn during XFER.
- A MOVI src field is never range-checked; all 64 immediate values are legal.
- The instruction must stay stable from SRC through DONE. If it changes but stays active, the enables follow the new fields combinationally. That case is a controller error and is not required behaviour.

Optional Feature:
- Macro: MOV_IDX_CHECK_EN.
- Defined:
  - err port exists.
  - In SRC, if dst >= NUM_REGS, or (MOV and src >= NUM_REGS), then err=1. The state goes to HOLD after SRC, skipping XFER and DONE, so there is no done pulse.
  - err stays 1 in HOLD and clears on IDLE or rst.
  - pcInc still pulses in SRC.
- Undefined:
  - No err port.
  - Illegal indices follow the all-zero one-hot rule, and done pulses normally.

Test Plan:
- rst=1 for 2 cycles with instruction=16'h5042 -> all outputs 0. Release rst -> SRC rxOut=6'b001000, pcInc=1. XFER rxOut=6'b001000, rxIn=6'b010000. DONE done=1. Then HOLD with outputs 0.
- MOVI instruction=16'hD0AA (dst=2, imm=6'h2A) -> SRC immEn=1, immData=6'h2A, rxOut=0. XFER rxIn=6'b001000. done pulses 1 cycle.
- XFER_CYCLES=3, MOV dst=0 src=5 -> rxOut=6'b000001 and rxIn=6'b100000 held 3 cycles. done in cycle 6. pcInc high exactly once.
- Abort: switch the opcode to 4'h0 during XFER -> next cycle IDLE, all outputs 0, no done. Restore the move opcode -> sequence restarts from SRC.
- rst asserted during XFER -> IDLE on that edge. Outputs 0 the following cycle. The counter restarts at 0 on the next run.
- src=7 with NUM_REGS=6: without the macro, rxOut=0 and done=1 at cycle 4. With MOV_IDX_CHECK_EN, err=1 from SRC onward and no done pulse.

Source files
------------

// File: rtl/mov_exec_fsm_if.sv
// Register-move bus bundle: the instruction word from the controller and the
// enables/strobes driven back by the move execution FSM.
// The err flag exists only when MOV_IDX_CHECK_EN is defined.
interface mov_exec_fsm_if #(
  parameter int NUM_REGS = 6
);
  logic [15:0]         instruction;
  logic                done;
  logic                pcInc;
  logic [NUM_REGS-1:0] rxOut;
  logic [NUM_REGS-1:0] rxIn;
  logic                immEn;
  logic [5:0]          immData;
`ifdef MOV_IDX_CHECK_EN
  logic                err;

  modport master (output instruction,
                  input  done, pcInc, rxOut, rxIn, immEn, immData, err);
  modport slave  (input  instruction,
                  output done, pcInc, rxOut, rxIn, immEn, immData, err);
`else
  modport master (output instruction,
                  input  done, pcInc, rxOut, rxIn, immEn, immData);
  modport slave  (input  instruction,
                  output done, pcInc, rxOut, rxIn, immEn, immData);
`endif
endinterface

// File: rtl/mov_exec_fsm.sv
// Execution FSM for MOV (register to register) and MOVI (6-bit immediate to
// register). Sequence: IDLE -> SRC -> XFER (XFER_CYCLES) -> DONE -> HOLD.
// Optional feature macro: MOV_IDX_CHECK_EN adds the err flag and skips the
// transfer when a register index is out of range.
module mov_exec_fsm #(
  parameter int         NUM_REGS    = 6,
  parameter logic [3:0] MOV_OPC     = 4'b0101,
  parameter logic [3:0] MOVI_OPC    = 4'b1101,
  parameter int         XFER_CYCLES = 1
) (
  input logic           clk,
  input logic           rst,
  mov_exec_fsm_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SRC, XFER, DONE, HOLD} state_t;

  localparam logic [3:0] XFER_LAST = 4'(XFER_CYCLES - 1);

  state_t state, state_nxt;
  logic [3:0] xfer_cnt, xfer_cnt_nxt;

  logic [3:0] opcode;
  logic [5:0] dst_idx;
  logic [5:0] src_idx;
  logic       is_mov;
  logic       is_movi;
  logic       active;
  logic [NUM_REGS-1:0] src_hot;
  logic [NUM_REGS-1:0] dst_hot;

  logic                done_d;
  logic                pc_inc_d;
  logic [NUM_REGS-1:0] rx_out_d;
  logic [NUM_REGS-1:0] rx_in_d;
  logic                imm_en_d;
  logic [5:0]          imm_data_d;

  // Register index to enable bit; bit NUM_REGS-1 is reg0, out-of-range gives zero
  function automatic logic [NUM_REGS-1:0] onehot(input logic [5:0] idx);
    logic [NUM_REGS-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (int'(idx) == NUM_REGS - 1 - k) r[k] = 1'b1;
    end
    return r;
  endfunction

  assign opcode  = bus.instruction[15:12];
  assign dst_idx = bus.instruction[11:6];
  assign src_idx = bus.instruction[5:0];
  assign is_mov  = (opcode == MOV_OPC);
  assign is_movi = (opcode == MOVI_OPC);
  assign active  = is_mov || is_movi;
  assign src_hot = onehot(src_idx);
  assign dst_hot = onehot(dst_idx);

`ifdef MOV_IDX_CHECK_EN
  logic idx_bad;
  logic err_q;
  logic err_d;

  assign idx_bad = (int'(dst_idx) >= NUM_REGS) ||
                   (is_mov && (int'(src_idx) >= NUM_REGS));

  // Remember an illegal-index abort so err stays up through HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state == SRC && active && idx_bad) begin
      err_q <= 1'b1;
    end else if (state_nxt == IDLE) begin
      err_q <= 1'b0;
    end
  end

  assign bus.err = err_d;
`endif

  // State register and transfer counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      xfer_cnt <= '0;
    end else begin
      state    <= state_nxt;
      xfer_cnt <= xfer_cnt_nxt;
    end
  end

  // Next state: any non-move opcode drops straight back to IDLE
  always_comb begin
    state_nxt    = state;
    xfer_cnt_nxt = '0;
    if (!active) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = SRC;
`ifdef MOV_IDX_CHECK_EN
        SRC:  state_nxt = idx_bad ? HOLD : XFER;
`else
        SRC:  state_nxt = XFER;
`endif
        XFER: begin
          if (xfer_cnt == XFER_LAST) begin
            state_nxt = DONE;
          end else begin
            xfer_cnt_nxt = xfer_cnt + 4'd1;
          end
        end
        DONE:    state_nxt = HOLD;
        HOLD:    state_nxt = HOLD;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Moore output decode from state and the held instruction fields
  always_comb begin
    done_d     = 1'b0;
    pc_inc_d   = 1'b0;
    rx_out_d   = '0;
    rx_in_d    = '0;
    imm_en_d   = 1'b0;
    imm_data_d = '0;
`ifdef MOV_IDX_CHECK_EN
    err_d      = 1'b0;
`endif
    case (state)
      SRC, XFER: begin
        if (is_movi) begin
          imm_en_d   = 1'b1;
          imm_data_d = src_idx;
        end else begin
          rx_out_d   = src_hot;
        end
        if (state == SRC) begin
          pc_inc_d = 1'b1;
`ifdef MOV_IDX_CHECK_EN
          err_d    = idx_bad;
`endif
        end else begin
          rx_in_d  = dst_hot;
        end
      end
      DONE: done_d = 1'b1;
`ifdef MOV_IDX_CHECK_EN
      HOLD: err_d  = err_q;
`endif
      default: ;
    endcase
  end

  assign bus.done    = done_d;
  assign bus.pcInc   = pc_inc_d;
  assign bus.rxOut   = rx_out_d;
  assign bus.rxIn    = rx_in_d;
  assign bus.immEn   = imm_en_d;
  assign bus.immData = imm_data_d;

endmodule

// File: tb/tb_mov_exec_fsm.sv
// Scoreboard bench for mov_exec_fsm: two instances (XFER_CYCLES 1 and 3) share
// the instruction stream; a cycle-count reference model predicts every output.
module tb_mov_exec_fsm;

  typedef struct packed {
    logic       chk;
    logic       done;
    logic       pcInc;
    logic [5:0] rxOut;
    logic [5:0] rxIn;
    logic       immEn;
    logic [5:0] immData;
    logic       err;
  } exp_t;

  logic        clk;
  logic        rstSig;
  logic [15:0] instr;

  int errors = 0;
  int checks = 0;
  int ph[2]  = '{-1, -1};
  exp_t q0[$];
  exp_t q1[$];

  mov_exec_fsm_if #(.NUM_REGS(6)) bus1 ();
  mov_exec_fsm_if #(.NUM_REGS(6)) bus3 ();

  assign bus1.instruction = instr;
  assign bus3.instruction = instr;

  mov_exec_fsm #(.NUM_REGS(6), .XFER_CYCLES(1)) dut1 (
    .clk(clk), .rst(rstSig), .bus(bus1.slave));
  mov_exec_fsm #(.NUM_REGS(6), .XFER_CYCLES(3)) dut3 (
    .clk(clk), .rst(rstSig), .bus(bus3.slave));

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [5:0] hotModel(input logic [5:0] i);
    logic [5:0] r;
    r = (i < 6) ? 6'(32 >> i) : 6'd0;
    return r;
  endfunction

  function automatic bit isActive(input logic [15:0] ins);
    return (ins[15:12] == 4'h5) || (ins[15:12] == 4'hD);
  endfunction

  function automatic bit illegalModel(input logic [15:0] ins);
    return (ins[11:6] >= 6) || (ins[15:12] == 4'h5 && ins[5:0] >= 6);
  endfunction

  // Phase = cycles since SRC began; -1 idle, 1000 means aborted on bad index
  function automatic int nextPhase(input int p, input logic r, input logic [15:0] ins);
    if (r || !isActive(ins)) return -1;
    if (p == -1) return 0;
`ifdef MOV_IDX_CHECK_EN
    if (p == 0 && illegalModel(ins)) return 1000;
`endif
    if (p < 999) return p + 1;
    return p;
  endfunction

  function automatic exp_t modelOut(input int xc, input int p, input logic [15:0] ins);
    exp_t e;
    e = '0;
    e.chk = 1'b1;
    if (p >= 0 && p <= xc) begin
      if (!isActive(ins)) begin
        e.chk = 1'b0;
        return e;
      end
      if (ins[15:12] == 4'hD) begin
        e.immEn   = 1'b1;
        e.immData = ins[5:0];
      end else begin
        e.rxOut = hotModel(ins[5:0]);
      end
      if (p == 0) begin
        e.pcInc = 1'b1;
`ifdef MOV_IDX_CHECK_EN
        e.err   = illegalModel(ins);
`endif
      end else begin
        e.rxIn = hotModel(ins[11:6]);
      end
    end else if (p == xc + 1) begin
      e.done = 1'b1;
    end
`ifdef MOV_IDX_CHECK_EN
    if (p == 1000) e.err = 1'b1;
`endif
    return e;
  endfunction

  // Hold instruction/reset for n clock edges, queueing the predicted outputs
  task automatic applyStimulus(input logic [15:0] ins, input logic r, input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      ph[0] = nextPhase(ph[0], rstSig, instr);
      ph[1] = nextPhase(ph[1], rstSig, instr);
      #1;
      instr  = ins;
      rstSig = r;
      q0.push_back(modelOut(1, ph[0], instr));
      q1.push_back(modelOut(3, ph[1], instr));
    end
  endtask

  task automatic checkOutput(input string name, input int d,
                             input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL dut%0d %s: got %0h expected %0h at %0t", d, name, act, expv, $time);
    end
  endtask

  task automatic checkSet(input int d, input exp_t e, input logic dn, input logic pc,
                          input logic [5:0] ro, input logic [5:0] ri, input logic ie,
                          input logic [5:0] id, input logic er);
    if (e.chk) begin
      checkOutput("done",    d, 32'(dn), 32'(e.done));
      checkOutput("pcInc",   d, 32'(pc), 32'(e.pcInc));
      checkOutput("rxOut",   d, 32'(ro), 32'(e.rxOut));
      checkOutput("rxIn",    d, 32'(ri), 32'(e.rxIn));
      checkOutput("immEn",   d, 32'(ie), 32'(e.immEn));
      checkOutput("immData", d, 32'(id), 32'(e.immData));
`ifdef MOV_IDX_CHECK_EN
      checkOutput("err",     d, 32'(er), 32'(e.err));
`else
      if (er !== 1'b0) checkOutput("err", d, 32'(er), 32'd0);
`endif
    end
  endtask

  // Monitor: pop one expectation per instance every falling edge
  initial begin
    exp_t e;
    logic er1, er3;
    forever begin
      @(negedge clk);
`ifdef MOV_IDX_CHECK_EN
      er1 = bus1.err;
      er3 = bus3.err;
`else
      er1 = 1'b0;
      er3 = 1'b0;
`endif
      if (q0.size() > 0) begin
        e = q0.pop_front();
        checkSet(1, e, bus1.done, bus1.pcInc, bus1.rxOut, bus1.rxIn,
                 bus1.immEn, bus1.immData, er1);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        checkSet(3, e, bus3.done, bus3.pcInc, bus3.rxOut, bus3.rxIn,
                 bus3.immEn, bus3.immData, er3);
      end
    end
  end

  // Driver: directed scenarios followed by randomized move transactions
  initial begin
    logic [3:0] opc;
    logic [5:0] dst, src;
    int len, cut;
    rstSig = 1'b1;
    instr  = 16'h5042;

    applyStimulus(16'h5042, 1'b1, 2);
    applyStimulus(16'h5042, 1'b0, 7);
    applyStimulus(16'h0000, 1'b0, 2);
    applyStimulus(16'hD0AA, 1'b0, 7);
    applyStimulus(16'h0000, 1'b0, 2);
    applyStimulus(16'h5005, 1'b0, 8);
    applyStimulus(16'h3000, 1'b0, 2);
    applyStimulus(16'h5042, 1'b0, 2);
    applyStimulus(16'h0000, 1'b0, 1);
    applyStimulus(16'h5042, 1'b0, 7);
    applyStimulus(16'h0000, 1'b0, 2);
    applyStimulus(16'h5042, 1'b0, 3);
    applyStimulus(16'h5042, 1'b1, 1);
    applyStimulus(16'h5042, 1'b0, 8);
    applyStimulus(16'h0000, 1'b0, 2);
    applyStimulus(16'h5047, 1'b0, 7);
    applyStimulus(16'h0000, 1'b0, 2);
    applyStimulus(16'h5F82, 1'b0, 7);
    applyStimulus(16'h0000, 1'b0, 2);
    applyStimulus(16'hD0FF, 1'b0, 7);
    applyStimulus(16'h0000, 1'b0, 2);
    applyStimulus(16'h5104, 1'b0, 7);
    applyStimulus(16'h0000, 1'b0, 2);

    for (int t = 0; t < 150; t++) begin
      opc = ($urandom_range(0, 1) == 0) ? 4'h5 : 4'hD;
      dst = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      src = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 9) == 0) begin
        cut = $urandom_range(1, 4);
        applyStimulus({opc, dst, src}, 1'b0, cut);
        applyStimulus({opc, dst, src}, 1'b1, 1);
      end
      applyStimulus({opc, dst, src}, 1'b0, len);
      do opc = 4'($urandom_range(0, 15)); while (opc == 4'h5 || opc == 4'hD);
      applyStimulus({opc, 12'($urandom)}, 1'b0, $urandom_range(1, 3));
    end

    for (int w = 0; w < 10 && (q0.size() > 0 || q1.size() > 0); w++) @(negedge clk);
    #2;
    if (q0.size() > 0 || q1.size() > 0) begin
      checkOutput("drain", 0, 32'(q0.size() + q1.size()), 32'd0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
